// File: rtl/dice_pkg.sv
// Purpose: shared constants, FSM state type and face-classification helpers for the dice turn engine.
// Latency: n/a (package; pure functions only).
// Backpressure: n/a.
package dice_pkg;

  localparam int unsigned      DEF_NUM_FACES  = 6;
  localparam logic [5:0]       DEF_BONUS_MASK = 6'b101000;
  localparam int unsigned      DEF_MAX_CHAIN  = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHAIN = 1'b1
  } state_e;

  // Legal faces are 1..num_faces; 0 and anything above are rejected.
  function automatic logic is_legal_face(input int unsigned face,
                                         input int unsigned num_faces = DEF_NUM_FACES);
    return (face != 0) && (face <= num_faces);
  endfunction

  // Bit f-1 of the mask marks face f as granting another throw.
  function automatic logic is_bonus_face(input int unsigned face,
                                         input logic [31:0] mask);
    if (face == 0 || face > 32) return 1'b0;
    return mask[face-1];
  endfunction

endpackage

// File: rtl/dice_player_ctr.sv
// Purpose: wrapping player index counter, 0..NUM-1, advanced by a single enable.
// Latency: 1 cycle from adv to updated cnt.
// Backpressure: none; the caller gates adv.
// Ports: clk, rst (sync active-high), adv (step to next player), cnt (current player).
module dice_player_ctr #(
  parameter int NUM = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      if (cnt_q == W'(NUM - 1)) cnt_d = '0;
      else                      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dice_turn_engine.sv
// Purpose: accumulate die faces into per-player turns with chained bonus throws; emit one move per turn.
// Latency: 1 cycle from the turn-completing roll to move_valid.
// Backpressure: roll_ready = !move_valid | move_ready; the pending move holds while stalled.
// Ports: clk, rst (sync active-high); roll_valid/roll_ready/roll_face in; move_valid/move_ready,
//   move, move_player, move_foul out; cur_player, extra_throw, bad_roll status.
// Optional: define DICE_STATS_EN to add turn_count[15:0] and foul_count[7:0] counted on move drain.
module dice_turn_engine
  import dice_pkg::*;
#(
  parameter int                    FACE_W      = 3,
  parameter int                    NUM_FACES   = DEF_NUM_FACES,
  parameter logic [NUM_FACES-1:0]  BONUS_MASK  = DEF_BONUS_MASK,
  parameter int                    MAX_CHAIN   = DEF_MAX_CHAIN,
  parameter int                    NUM_PLAYERS = 4,
  parameter int                    MOVE_W      = $clog2(MAX_CHAIN*NUM_FACES+1),
  parameter int                    PLR_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              roll_valid,
  input  logic [FACE_W-1:0] roll_face,
  output logic              roll_ready,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [MOVE_W-1:0] move,
  output logic [PLR_W-1:0]  move_player,
  output logic              move_foul,
  output logic [PLR_W-1:0]  cur_player,
  output logic              extra_throw,
  output logic              bad_roll
`ifdef DICE_STATS_EN
  ,
  output logic [15:0]       turn_count,
  output logic [7:0]        foul_count
`endif
);

  localparam int CH_W = (MAX_CHAIN > 1) ? $clog2(MAX_CHAIN + 1) : 1;

  state_e             state_q, state_d;
  logic [MOVE_W-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]    chain_q, chain_d;
  logic               move_valid_q, move_valid_d;
  logic [MOVE_W-1:0]  move_q, move_d;
  logic [PLR_W-1:0]   move_player_q, move_player_d;
  logic               move_foul_q, move_foul_d;
  logic               bad_roll_q, bad_roll_d;
  logic               adv;

  logic roll_acc, move_drain, face_legal, face_bonus;

  assign roll_ready = !move_valid_q || move_ready;
  assign roll_acc   = roll_valid && roll_ready;
  assign move_drain = move_valid_q && move_ready;
  assign face_legal = is_legal_face(32'(roll_face), NUM_FACES);
  assign face_bonus = is_bonus_face(32'(roll_face), 32'(BONUS_MASK));

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    chain_d       = chain_q;
    move_valid_d  = move_valid_q;
    move_d        = move_q;
    move_player_d = move_player_q;
    move_foul_d   = move_foul_q;
    bad_roll_d    = 1'b0;
    adv           = 1'b0;

    // A drained move clears valid unless this same cycle's roll completes a new turn.
    if (move_drain) move_valid_d = 1'b0;

    if (roll_acc) begin
      if (!face_legal) begin
        bad_roll_d = 1'b1;
      end else if (face_bonus && (32'(chain_q) + 1 < MAX_CHAIN)) begin
        acc_d   = acc_q + MOVE_W'(roll_face);
        chain_d = chain_q + CH_W'(1);
        state_d = CHAIN;
      end else begin
        // Either a normal turn end or a bonus on the last allowed throw (forfeit).
        move_valid_d  = 1'b1;
        move_player_d = cur_player;
        move_foul_d   = face_bonus;
        move_d        = face_bonus ? '0 : acc_q + MOVE_W'(roll_face);
        acc_d         = '0;
        chain_d       = '0;
        state_d       = IDLE;
        adv           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      chain_q       <= '0;
      move_valid_q  <= 1'b0;
      move_q        <= '0;
      move_player_q <= '0;
      move_foul_q   <= 1'b0;
      bad_roll_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      chain_q       <= chain_d;
      move_valid_q  <= move_valid_d;
      move_q        <= move_d;
      move_player_q <= move_player_d;
      move_foul_q   <= move_foul_d;
      bad_roll_q    <= bad_roll_d;
    end
  end

  dice_player_ctr #(
    .NUM (NUM_PLAYERS),
    .W   (PLR_W)
  ) u_player_ctr (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .cnt (cur_player)
  );

  assign move_valid  = move_valid_q;
  assign move        = move_q;
  assign move_player = move_player_q;
  assign move_foul   = move_foul_q;
  assign bad_roll    = bad_roll_q;
  // Mid-chain is exactly the CHAIN state, which is itself a flop.
  assign extra_throw = (state_q == CHAIN);

`ifdef DICE_STATS_EN
  logic [15:0] turn_cnt_q, turn_cnt_d;
  logic [7:0]  foul_cnt_q, foul_cnt_d;

  always_comb begin
    turn_cnt_d = turn_cnt_q;
    foul_cnt_d = foul_cnt_q;
    if (move_drain) begin
      if (turn_cnt_q != 16'hFFFF) turn_cnt_d = turn_cnt_q + 16'd1;
      if (move_foul_q && foul_cnt_q != 8'hFF) foul_cnt_d = foul_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      turn_cnt_q <= '0;
      foul_cnt_q <= '0;
    end else begin
      turn_cnt_q <= turn_cnt_d;
      foul_cnt_q <= foul_cnt_d;
    end
  end

  assign turn_count = turn_cnt_q;
  assign foul_count = foul_cnt_q;
`endif

endmodule

// File: tb/tb_dice_turn_engine.sv
// Purpose: directed self-checking bench for dice_turn_engine with a move scoreboard.
// Latency: n/a.
// Backpressure: drives move_ready low for a stall window.
module tb_dice_turn_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll_valid;
  logic [2:0] roll_face;
  logic       roll_ready;
  logic       move_valid;
  logic       move_ready;
  logic [4:0] move;
  logic [1:0] move_player;
  logic       move_foul;
  logic [1:0] cur_player;
  logic       extra_throw;
  logic       bad_roll;
`ifdef DICE_STATS_EN
  logic [15:0] turn_count;
  logic [7:0]  foul_count;
`endif

  always #5 clk = ~clk;

  dice_turn_engine dut (
    .clk         (clk),
    .rst         (rst),
    .roll_valid  (roll_valid),
    .roll_face   (roll_face),
    .roll_ready  (roll_ready),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move        (move),
    .move_player (move_player),
    .move_foul   (move_foul),
    .cur_player  (cur_player),
    .extra_throw (extra_throw),
    .bad_roll    (bad_roll)
`ifdef DICE_STATS_EN
    ,
    .turn_count  (turn_count),
    .foul_count  (foul_count)
`endif
  );

  typedef struct packed {
    logic [4:0] mv;
    logic [1:0] pl;
    logic       foul;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a move is consumed at the posedge following a negedge where valid & ready.
  always @(negedge clk) begin
    if (!rst && move_valid && move_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL move_unexpected: got move=%0d player=%0d foul=%0d, expected none",
                 move, move_player, move_foul);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (move !== e.mv || move_player !== e.pl || move_foul !== e.foul) begin
          fails++;
          $display("FAIL move_result: got move=%0d player=%0d foul=%0d, expected move=%0d player=%0d foul=%0d",
                   move, move_player, move_foul, e.mv, e.pl, e.foul);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic roll(input logic [2:0] f);
    roll_valid = 1'b1;
    roll_face  = f;
    tick();
    roll_valid = 1'b0;
  endtask

  task automatic expect_move(input int mv, input int pl, input int foul);
    exp_t e;
    e.mv   = 5'(mv);
    e.pl   = 2'(pl);
    e.foul = foul[0];
    exp_q.push_back(e);
  endtask

  initial begin
    rst        = 1'b1;
    roll_valid = 1'b0;
    roll_face  = '0;
    move_ready = 1'b1;
    tick();
    tick();
    check("rst_move_valid", int'(move_valid), 0);
    check("rst_cur_player", int'(cur_player), 0);
    check("rst_extra", int'(extra_throw), 0);
    check("rst_bad_roll", int'(bad_roll), 0);
    rst = 1'b0;
    tick();

    // Single non-bonus roll.
    expect_move(3, 0, 0);
    roll(3'd3);
    check("t1_move_valid", int'(move_valid), 1);
    check("t1_cur_player", int'(cur_player), 1);

    // Chain 4,6 then 2 on the third throw.
    roll(3'd4);
    check("t2_extra_after4", int'(extra_throw), 1);
    check("t2_valid_dropped", int'(move_valid), 0);
    roll(3'd6);
    check("t2_extra_after6", int'(extra_throw), 1);
    check("t2_player_held", int'(cur_player), 1);
    expect_move(12, 1, 0);
    roll(3'd2);
    check("t2_extra_clear", int'(extra_throw), 0);
    check("t2_cur_player", int'(cur_player), 2);

    // Bonus on the last allowed throw forfeits.
    roll(3'd4);
    roll(3'd6);
    expect_move(0, 2, 1);
    roll(3'd4);
    check("t3_move_foul", int'(move_foul), 1);
    check("t3_cur_player", int'(cur_player), 3);
    check("t3_extra", int'(extra_throw), 0);

    // Illegal faces: forfeit move drains on this edge, no state change.
    roll(3'd0);
    check("t4_bad_roll0", int'(bad_roll), 1);
    check("t4_no_move", int'(move_valid), 0);
`ifdef DICE_STATS_EN
    check("t3_foul_count", int'(foul_count), 1);
    check("t3_turn_count", int'(turn_count), 3);
`endif
    roll(3'd7);
    check("t4_bad_roll7", int'(bad_roll), 1);
    tick();
    check("t4_bad_roll_clear", int'(bad_roll), 0);
    check("t4_cur_player", int'(cur_player), 3);
    check("t4_extra", int'(extra_throw), 0);
    check("t4_no_move2", int'(move_valid), 0);

    // Backpressure; player index wraps 3 -> 0.
    move_ready = 1'b0;
    expect_move(5, 3, 0);
    roll(3'd5);
    check("t5_cur_player_wrap", int'(cur_player), 0);
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", int'(move_valid), 1);
      check("t5_hold_move", int'(move), 5);
      check("t5_hold_player", int'(move_player), 3);
      check("t5_roll_ready", int'(roll_ready), 0);
      tick();
    end
    move_ready = 1'b1;
    expect_move(2, 0, 0);
    roll(3'd2);
    check("t5_valid_stays", int'(move_valid), 1);
    check("t5_new_move", int'(move), 2);
    check("t5_cur_player", int'(cur_player), 1);

    // Reset mid-chain discards the partial turn.
    roll(3'd6);
    check("t6_extra", int'(extra_throw), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", int'(move_valid), 0);
    check("t6_rst_move", int'(move), 0);
    check("t6_rst_player", int'(cur_player), 0);
    check("t6_rst_extra", int'(extra_throw), 0);
    expect_move(1, 0, 0);
    roll(3'd1);
    check("t6_move_after_rst", int'(move), 1);
    check("t6_cur_player", int'(cur_player), 1);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
